// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 decrypt / key-search blocks.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_RD_SI,
    ST_CAP_SI,
    ST_RD_SJ,
    ST_CAP_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_F,
    ST_CAP_F,
    ST_WR_DEC,
    ST_DONE
  } state_e;

  localparam int DEFAULT_MSG_LEN = 32;

  localparam logic [7:0] CHAR_A     = 8'h61;
  localparam logic [7:0] CHAR_Z     = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // A one-byte message still needs a 1-bit address port.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rc4_char_check.sv
// Accepts lowercase ASCII letters and space; shared with the key-search controller.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       valid_o
);

  assign valid_o = ((char_i >= CHAR_A) && (char_i <= CHAR_Z)) || (char_i == CHAR_SPACE);

endmodule

// File: rtl/rc4_decrypt_prga.sv
// RC4 keystream generation over a pre-shuffled S RAM, decrypting the message ROM
// into the decrypted RAM and reporting whether every byte is printable lowercase.
module rc4_decrypt_prga
  import rc4_pkg::*;
#(
  parameter  int MSG_LEN = DEFAULT_MSG_LEN,
  localparam int AW      = addr_w(MSG_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          key_valid,
  output logic [7:0]    s_addr,
  output logic [7:0]    s_write_data,
  output logic          s_wr_en,
  input  logic [7:0]    mem_s_read_data,
  output logic [AW-1:0] enc_addr,
  input  logic [7:0]    enc_read_data,
  output logic [AW-1:0] dec_addr,
  output logic [7:0]    dec_write_data,
  output logic          dec_wr_en
);

  state_e        state_q;
  logic [7:0]    i_q, j_q, si_q, sj_q;
  logic [AW-1:0] k_q;
  logic          done_q, key_valid_q;
  logic [7:0]    s_addr_q, s_wdata_q;
  logic          s_we_q;
  logic [AW-1:0] enc_addr_q, dec_addr_q;
  logic [7:0]    dec_wdata_q;
  logic          dec_we_q;
  logic          char_ok;

  rc4_char_check u_char_check (
    .char_i  (dec_wdata_q),
    .valid_o (char_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_we_q      <= 1'b0;
      enc_addr_q  <= '0;
      dec_addr_q  <= '0;
      dec_wdata_q <= '0;
      dec_we_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            key_valid_q <= 1'b0;
            state_q     <= ST_INC_I;
          end
        end
        ST_INC_I: begin
          i_q      <= i_q + 8'd1;
          s_addr_q <= i_q + 8'd1;
          state_q  <= ST_RD_SI;
        end
        ST_RD_SI: state_q <= ST_CAP_SI;
        ST_CAP_SI: begin
          si_q     <= mem_s_read_data;
          j_q      <= j_q + mem_s_read_data;
          s_addr_q <= j_q + mem_s_read_data;
          state_q  <= ST_RD_SJ;
        end
        ST_RD_SJ: state_q <= ST_CAP_SJ;
        // Swap as two back-to-back writes; i==j simply writes the same value twice.
        ST_CAP_SJ: begin
          sj_q      <= mem_s_read_data;
          s_addr_q  <= i_q;
          s_wdata_q <= mem_s_read_data;
          s_we_q    <= 1'b1;
          state_q   <= ST_WR_SI;
        end
        ST_WR_SI: begin
          s_addr_q  <= j_q;
          s_wdata_q <= si_q;
          s_we_q    <= 1'b1;
          state_q   <= ST_WR_SJ;
        end
        ST_WR_SJ: begin
          s_we_q     <= 1'b0;
          s_addr_q   <= si_q + sj_q;
          enc_addr_q <= k_q;
          state_q    <= ST_RD_F;
        end
        ST_RD_F: state_q <= ST_CAP_F;
        ST_CAP_F: begin
          dec_wdata_q <= mem_s_read_data ^ enc_read_data;
          dec_addr_q  <= k_q;
          dec_we_q    <= 1'b1;
          state_q     <= ST_WR_DEC;
        end
        ST_WR_DEC: begin
          dec_we_q <= 1'b0;
          if (!char_ok) begin
            key_valid_q <= 1'b0;
            state_q     <= ST_DONE;
          end else if (k_q == AW'(MSG_LEN - 1)) begin
            key_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            k_q     <= k_q + 1'b1;
            state_q <= ST_INC_I;
          end
        end
        // done is shown for at least one cycle even if start already dropped.
        ST_DONE: begin
          if (done_q && !start) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign done           = done_q;
  assign key_valid      = key_valid_q;
  assign s_addr         = s_addr_q;
  assign s_write_data   = s_wdata_q;
  assign s_wr_en        = s_we_q;
  assign enc_addr       = enc_addr_q;
  assign dec_addr       = dec_addr_q;
  assign dec_write_data = dec_wdata_q;
  assign dec_wr_en      = dec_we_q;

endmodule
